dc_tagbank_resp: RTL
====================

// Module: dc_tagbank_resp
// PURPOSE
//  Responder side of the DC tag-check interface: holds the L1 D-cache tag array (SETS x WAYS entries of
//  tag + 2b SRRIP counter + 3b coherence state) and serves lookup/fill/state-update/invalidate requests.
//  Returns hit, way, state, and on a miss an SRRIP victim way with its tag and state for L2 writeback.
//  Sits between the tag-check initiator and the tag storage; one request in flight, one-entry ack register.
// PARAMETERS
//  SETS      32  number of sets; SET_BITS = log2(SETS)
//  WAYS      8   associativity; WAY_BITS = log2(WAYS)
//  TAG_BITS  18  address tag width
// PORTS
//  clk            in   1         clock; all state updates on the rising edge
//  reset          in   1         synchronous, active-high reset
//  req_valid      in   1         request present
//  req_op         in   2         0 LOOKUP, 1 FILL, 2 SETST, 3 INVAL
//  req_set        in   SET_BITS  set index
//  req_tag        in   TAG_BITS  tag to compare (LOOKUP) or write (FILL)
//  req_way        in   WAY_BITS  target way for FILL/SETST/INVAL
//  req_state      in   3         state written by FILL/SETST
//  req_retry      out  1         request not accepted this cycle
//  ack_valid      out  1         response present
//  ack_retry      in   1         consumer stalls response
//  ack_op         out  2         op of the responded request
//  ack_hit        out  1         LOOKUP tag matched a non-I entry
//  ack_way        out  WAY_BITS  hit way, or victim way on miss, or req_way for other ops
//  ack_state      out  3         state of hit way; state of victim on miss
//  ack_vtag       out  TAG_BITS  tag of victim way (valid when LOOKUP miss and ack_state!=I)
//  ack_perr       out  1         parity error seen (only with DC_TAGBANK_PARITY_EN, else tied 0)
// BEHAVIOUR
//  - Handshake: transfer when valid && !retry. req_retry = ack_valid && ack_retry (combinational).
//  - Latency 1: request accepted in cycle N -> ack_valid high from N+1 until cycle with !ack_retry.
//  - Array update for the accepted request commits at the end of cycle N; a request accepted in N+1
//    to the same set sees it (no forwarding needed, array is flops).
//  - LOOKUP hit: ack_hit=1, ack_way=lowest matching way, counter[way]<=0, state unchanged.
//  - LOOKUP miss: victim = lowest way with state I; else lowest way with max counter m; all non-I
//    counters in set += (3-m) (saturate at 3). ack_hit=0; array tags/states unchanged.
//  - FILL: entry[req_way] <= {req_tag, ctr=2, req_state}; ack_hit=0, ack_way=req_way.
//  - SETST: state[req_way] <= req_state; tag/counter unchanged. INVAL: state <= I, counter <= 3.
//  - Multiple tag matches are illegal (asserted in sim); lowest way wins in RTL.
//  - Reset: all entries state I, counter 3, tag 0; ack_valid=0, all ack_* = 0, req_retry=0.
//    Reset while an ack is pending drops it; no request accepted in a reset cycle.
//  - State encoding: I=0, S=1, E=2, M=3, US=4, UM=5; 6,7 reserved (write-through, treated non-I).
// CONFIGURATION
//  DC_TAGBANK_PARITY_EN defined: one even-parity bit per entry over {tag,state}, written by
//    FILL/SETST/INVAL. LOOKUP reading a bad-parity entry treats it as I (no hit on it), sets ack_perr=1;
//    entry is not scrubbed. Undefined: no parity storage, ack_perr constant 0.
// STRUCTURE
//  - Package dc_tag_pkg: op enum (LOOKUP/FILL/SETST/INVAL), state enum, tag_entry_t struct
//    {tag, rrpv[1:0], state[2:0]}, RRPV_INSERT=2, RRPV_MAX=3.
//  - Sub-module dc_tag_rrip_victim: combinational, input WAYS entries of one set, output victim way,
//    max counter and per-way aged counters. Top holds array, ack register, handshake.
// TESTING
//  1 Reset then LOOKUP set 5 tag 0x1234 -> ack N+1: hit=0, way=0, state=I, perr=0.
//  2 FILL set 5 way 3 tag 0x1234 state E; LOOKUP same -> hit=1, way=3, state=E; counter[3]=0.
//  3 Fill all 8 ways set 7 (ctr 2), hit way 0 (ctr 0); LOOKUP miss tag 0x3FFFF -> way=1,
//    vtag=way1 tag; then counters: way0=1, ways1-7=3.
//  4 Hold ack_retry=1 for 3 cycles with req_valid=1 -> req_retry=1 all 3, ack fields stable,
//    next request accepted same cycle ack_retry drops; no loss or duplicate.
//  5 Back-to-back SETST set 2 way 4 UM, LOOKUP same tag -> hit=1, state=5; INVAL then LOOKUP -> hit=0.
//  6 Assert reset with ack_valid=1 -> ack_valid=0 next cycle; prior filled tag no longer hits.
//    With PARITY_EN: force flip tag bit of hit entry -> LOOKUP hit=0, perr=1.

Source files
------------

// File: rtl/dc_tagbank_resp_pkg.sv
// Shared types and constants for the DC tag bank responder: geometry,
// request opcodes, coherence states, the tag entry layout and its parity.
package dc_tag_pkg;

    localparam int SETS     = 32;
    localparam int WAYS     = 8;
    localparam int TAG_BITS = 18;
    localparam int SET_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FILL   = 2'd1,
        OP_SETST  = 2'd2,
        OP_INVAL  = 2'd3
    } op_e;

    // 6 and 7 are write-through encodings; they count as valid (non-I) lines.
    typedef enum logic [2:0] {
        ST_I    = 3'd0,
        ST_S    = 3'd1,
        ST_E    = 3'd2,
        ST_M    = 3'd3,
        ST_US   = 3'd4,
        ST_UM   = 3'd5,
        ST_WT6  = 3'd6,
        ST_WT7  = 3'd7
    } state_e;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [1:0]          rrpv;
        logic [2:0]          state;
    } tag_entry_t;

    localparam logic [1:0] RRPV_INSERT = 2'd2;
    localparam logic [1:0] RRPV_MAX    = 2'd3;

    // Even parity over the fields that identify the line; the replacement
    // counter is excluded so lookups can age it without rewriting parity.
    function automatic logic entry_parity(input tag_entry_t e);
        return ^{e.tag, e.state};
    endfunction

endpackage

// File: rtl/dc_tagbank_resp_if.sv
// Tag-check request/response channel between the initiator (master) and
// the tag bank responder (slave).
interface dc_tagbank_resp_if;
    import dc_tag_pkg::*;

    logic                req_valid;
    logic [1:0]          req_op;
    logic [SET_BITS-1:0] req_set;
    logic [TAG_BITS-1:0] req_tag;
    logic [WAY_BITS-1:0] req_way;
    logic [2:0]          req_state;
    logic                req_retry;

    logic                ack_valid;
    logic                ack_retry;
    logic [1:0]          ack_op;
    logic                ack_hit;
    logic [WAY_BITS-1:0] ack_way;
    logic [2:0]          ack_state;
    logic [TAG_BITS-1:0] ack_vtag;
    logic                ack_perr;

    modport master (
        output req_valid, req_op, req_set, req_tag, req_way, req_state, ack_retry,
        input  req_retry, ack_valid, ack_op, ack_hit, ack_way, ack_state, ack_vtag, ack_perr
    );

    modport slave (
        input  req_valid, req_op, req_set, req_tag, req_way, req_state, ack_retry,
        output req_retry, ack_valid, ack_op, ack_hit, ack_way, ack_state, ack_vtag, ack_perr
    );

endinterface

// File: rtl/dc_tagbank_resp_victim.sv
// SRRIP victim selection for one set (dc_tag_rrip_victim). Purely
// combinational: picks the lowest invalid way, otherwise the lowest way
// holding the largest counter, and produces the aged counters to write back
// on a miss with no invalid way.
module dc_tag_rrip_victim
    import dc_tag_pkg::*;
(
    input  tag_entry_t [WAYS-1:0]      set_i,
    input  logic       [WAYS-1:0]      inv_i,
    output logic       [WAY_BITS-1:0]  victim_o,
    output logic       [1:0]           max_rrpv_o,
    output logic       [WAYS-1:0][1:0] aged_rrpv_o
);

    logic       found_inv;
    logic [2:0] sum;

    // victim pick, max counter and saturating aging of the valid ways
    always_comb begin
        found_inv   = 1'b0;
        victim_o    = '0;
        max_rrpv_o  = '0;
        sum         = '0;
        aged_rrpv_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (inv_i[w]) begin
                found_inv = 1'b1;
                victim_o  = w[WAY_BITS-1:0];
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_i[w] && set_i[w].rrpv > max_rrpv_o) begin
                max_rrpv_o = set_i[w].rrpv;
            end
        end
        if (!found_inv) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (set_i[w].rrpv == max_rrpv_o) begin
                    victim_o = w[WAY_BITS-1:0];
                end
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            aged_rrpv_o[w] = set_i[w].rrpv;
            if (!found_inv && !inv_i[w]) begin
                sum = {1'b0, set_i[w].rrpv} + {1'b0, RRPV_MAX - max_rrpv_o};
                aged_rrpv_o[w] = (sum > 3'd3) ? RRPV_MAX : sum[1:0];
            end
        end
    end

endmodule

// File: rtl/dc_tagbank_resp.sv
// DC tag bank responder: holds the SETS x WAYS tag array, serves
// LOOKUP/FILL/SETST/INVAL one at a time and returns the result through a
// single-entry ack register that stalls new requests while it is held.
// Optional build macro DC_TAGBANK_PARITY_EN adds a per-entry parity bit;
// lookups ignore bad-parity entries and flag ack_perr.
module dc_tagbank_resp
    import dc_tag_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dc_tagbank_resp_if.slave bus
);

    localparam tag_entry_t RST_ENTRY = '{tag: '0, rrpv: RRPV_MAX, state: ST_I};

    tag_entry_t [WAYS-1:0] entries_q [SETS];
    tag_entry_t [WAYS-1:0] entries_d [SETS];
    tag_entry_t [WAYS-1:0] cur_set;

    logic [WAYS-1:0]      bad, inv, match;
    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way, victim_way;
    logic [1:0]           max_rrpv;
    logic [WAYS-1:0][1:0] aged_rrpv;
    logic                 req_retry, accept;

    logic                ack_valid_q, ack_valid_d;
    logic [1:0]          ack_op_q, ack_op_d;
    logic                ack_hit_q, ack_hit_d;
    logic [WAY_BITS-1:0] ack_way_q, ack_way_d;
    logic [2:0]          ack_state_q, ack_state_d;
    logic [TAG_BITS-1:0] ack_vtag_q, ack_vtag_d;
`ifdef DC_TAGBANK_PARITY_EN
    logic                ack_perr_q, ack_perr_d;
    logic [WAYS-1:0]     par_q [SETS];
    logic [WAYS-1:0]     par_d [SETS];
`endif

    assign cur_set = entries_q[bus.req_set];

    // per-way parity health, effective invalid mask and lowest-way tag hit
    always_comb begin
        bad     = '0;
        inv     = '0;
        match   = '0;
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
`ifdef DC_TAGBANK_PARITY_EN
            bad[w] = par_q[bus.req_set][w] != entry_parity(cur_set[w]);
`endif
            inv[w]   = (cur_set[w].state == ST_I) || bad[w];
            match[w] = !inv[w] && (cur_set[w].tag == bus.req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit     = 1'b1;
                hit_way = w[WAY_BITS-1:0];
            end
        end
    end

    dc_tag_rrip_victim u_victim (
        .set_i       (cur_set),
        .inv_i       (inv),
        .victim_o    (victim_way),
        .max_rrpv_o  (max_rrpv),
        .aged_rrpv_o (aged_rrpv)
    );

    assign req_retry = ack_valid_q && bus.ack_retry;
    assign accept    = bus.req_valid && !req_retry;

    // array update and ack capture for the request accepted this cycle
    always_comb begin
        entries_d   = entries_q;
        ack_valid_d = ack_valid_q && bus.ack_retry;
        ack_op_d    = ack_op_q;
        ack_hit_d   = ack_hit_q;
        ack_way_d   = ack_way_q;
        ack_state_d = ack_state_q;
        ack_vtag_d  = ack_vtag_q;
`ifdef DC_TAGBANK_PARITY_EN
        ack_perr_d  = ack_perr_q;
        par_d       = par_q;
`endif
        if (accept) begin
            ack_valid_d = 1'b1;
            ack_op_d    = bus.req_op;
            ack_hit_d   = 1'b0;
            ack_way_d   = bus.req_way;
            ack_state_d = bus.req_state;
            ack_vtag_d  = '0;
`ifdef DC_TAGBANK_PARITY_EN
            ack_perr_d  = 1'b0;
`endif
            case (bus.req_op)
                OP_LOOKUP: begin
`ifdef DC_TAGBANK_PARITY_EN
                    ack_perr_d = |bad;
`endif
                    if (hit) begin
                        ack_hit_d   = 1'b1;
                        ack_way_d   = hit_way;
                        ack_state_d = cur_set[hit_way].state;
                        entries_d[bus.req_set][hit_way].rrpv = 2'd0;
                    end else begin
                        ack_way_d   = victim_way;
                        ack_state_d = inv[victim_way] ? ST_I : cur_set[victim_way].state;
                        ack_vtag_d  = cur_set[victim_way].tag;
                        for (int w = 0; w < WAYS; w++) begin
                            entries_d[bus.req_set][w].rrpv = aged_rrpv[w];
                        end
                    end
                end
                OP_FILL: begin
                    entries_d[bus.req_set][bus.req_way] =
                        '{tag: bus.req_tag, rrpv: RRPV_INSERT, state: bus.req_state};
                end
                OP_SETST: begin
                    entries_d[bus.req_set][bus.req_way].state = bus.req_state;
                end
                default: begin
                    ack_state_d = ST_I;
                    entries_d[bus.req_set][bus.req_way].state = ST_I;
                    entries_d[bus.req_set][bus.req_way].rrpv  = RRPV_MAX;
                end
            endcase
`ifdef DC_TAGBANK_PARITY_EN
            if (bus.req_op != OP_LOOKUP) begin
                par_d[bus.req_set][bus.req_way] =
                    entry_parity(entries_d[bus.req_set][bus.req_way]);
            end
`endif
        end
    end

    // state registers; reset empties the array and drops any pending ack
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    entries_q[s][w] <= RST_ENTRY;
                end
`ifdef DC_TAGBANK_PARITY_EN
                par_q[s] <= '0;
`endif
            end
            ack_valid_q <= 1'b0;
            ack_op_q    <= '0;
            ack_hit_q   <= 1'b0;
            ack_way_q   <= '0;
            ack_state_q <= '0;
            ack_vtag_q  <= '0;
`ifdef DC_TAGBANK_PARITY_EN
            ack_perr_q  <= 1'b0;
`endif
        end else begin
            entries_q   <= entries_d;
            ack_valid_q <= ack_valid_d;
            ack_op_q    <= ack_op_d;
            ack_hit_q   <= ack_hit_d;
            ack_way_q   <= ack_way_d;
            ack_state_q <= ack_state_d;
            ack_vtag_q  <= ack_vtag_d;
`ifdef DC_TAGBANK_PARITY_EN
            ack_perr_q  <= ack_perr_d;
            par_q       <= par_d;
`endif
        end
    end

    // simulation checks: duplicate tags in a set and victim/max consistency
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.req_op == OP_LOOKUP) begin
            assert ($onehot0(match));
            assert (hit || (|inv) || cur_set[victim_way].rrpv == max_rrpv);
        end
    end

    assign bus.req_retry = req_retry;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_op    = ack_op_q;
    assign bus.ack_hit   = ack_hit_q;
    assign bus.ack_way   = ack_way_q;
    assign bus.ack_state = ack_state_q;
    assign bus.ack_vtag  = ack_vtag_q;
`ifdef DC_TAGBANK_PARITY_EN
    assign bus.ack_perr  = ack_perr_q;
`else
    assign bus.ack_perr  = 1'b0;
`endif

endmodule
